// File: rtl/page_table_walker.sv
// page_table_walker: two-level page-table walker that turns a TLB miss into a fill pulse or a fault.
// Optional memory-response timeout is compiled in with `define PTW_TIMEOUT_EN.
module page_table_walker #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] ptbr,
    input  logic        miss_valid,
    input  logic [19:0] miss_vpn,
    output logic        miss_ready,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        fill_we,
    output logic [19:0] fill_vpn,
    output logic [19:0] fill_ppn,
    output logic        fill_dirty,
    output logic        fault,
    output logic [19:0] fault_vpn,
    output logic [1:0]  fault_cause,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, FILL, FAULT
    } state_t;

    localparam logic [1:0] CAUSE_L1      = 2'b01;
    localparam logic [1:0] CAUSE_L2      = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("page_table_walker: TIMEOUT_CYCLES must be within 1..255");
    end

    state_t      state, state_nx;
    logic [19:0] vpn, vpn_nx;
    logic [31:0] req_addr_nx;
    logic        fill_we_nx;
    logic [19:0] fill_vpn_nx, fill_ppn_nx;
    logic        fill_dirty_nx;
    logic        fault_nx;
    logic [19:0] fault_vpn_nx;
    logic [1:0]  fault_cause_nx;

    // PTE bits [11:2] carry nothing this walker uses.
    logic unused_pte_bits;
    assign unused_pte_bits = ^mem_resp_data[11:2];

`ifdef PTW_TIMEOUT_EN
    logic [7:0] wait_cnt, wait_cnt_nx;
    logic       timed_out;
    assign timed_out = ({1'b0, wait_cnt} + 9'd1) == 9'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latches are inferred.
        state_nx       = state;
        vpn_nx         = vpn;
        req_addr_nx    = mem_req_addr;
        fill_we_nx     = 1'b0;
        fill_vpn_nx    = fill_vpn;
        fill_ppn_nx    = fill_ppn;
        fill_dirty_nx  = fill_dirty;
        fault_nx       = 1'b0;
        fault_vpn_nx   = fault_vpn;
        fault_cause_nx = fault_cause;
`ifdef PTW_TIMEOUT_EN
        wait_cnt_nx    = wait_cnt;
`endif
        case (state)
            IDLE: begin
                if (miss_valid && miss_ready) begin
                    vpn_nx      = miss_vpn;
                    req_addr_nx = {ptbr, 12'b0} + {20'b0, miss_vpn[19:10], 2'b00};
                    state_nx    = L1_REQ;
                end
            end
            L1_REQ, L2_REQ: begin
                if (mem_req_ready) begin
                    state_nx = (state == L1_REQ) ? L1_WAIT : L2_WAIT;
`ifdef PTW_TIMEOUT_EN
                    wait_cnt_nx = '0;
`endif
                end
            end
            L1_WAIT, L2_WAIT: begin
                if (mem_resp_valid) begin
                    if (!mem_resp_data[0]) begin
                        state_nx       = FAULT;
                        fault_nx       = 1'b1;
                        fault_vpn_nx   = vpn;
                        fault_cause_nx = (state == L1_WAIT) ? CAUSE_L1 : CAUSE_L2;
                    end else if (state == L1_WAIT) begin
                        // The L1 PTE's PPN is the L2 table base; fold it straight into the next address.
                        req_addr_nx = {mem_resp_data[31:12], 12'b0} + {20'b0, vpn[9:0], 2'b00};
                        state_nx    = L2_REQ;
                    end else begin
                        state_nx      = FILL;
                        fill_we_nx    = 1'b1;
                        fill_vpn_nx   = vpn;
                        fill_ppn_nx   = mem_resp_data[31:12];
                        fill_dirty_nx = mem_resp_data[1];
                    end
                end
`ifdef PTW_TIMEOUT_EN
                else if (timed_out) begin
                    state_nx       = FAULT;
                    fault_nx       = 1'b1;
                    fault_vpn_nx   = vpn;
                    fault_cause_nx = CAUSE_TIMEOUT;
                end else begin
                    wait_cnt_nx = wait_cnt + 8'd1;
                end
`endif
            end
            FILL, FAULT: state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    // NOTE: outputs are registered from next-state values so each lines up with the state it describes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            vpn           <= '0;
            miss_ready    <= 1'b1;
            busy          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            fill_we       <= 1'b0;
            fill_vpn      <= '0;
            fill_ppn      <= '0;
            fill_dirty    <= 1'b0;
            fault         <= 1'b0;
            fault_vpn     <= '0;
            fault_cause   <= '0;
`ifdef PTW_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            state         <= state_nx;
            vpn           <= vpn_nx;
            miss_ready    <= (state_nx == IDLE);
            busy          <= (state_nx != IDLE);
            mem_req_valid <= (state_nx == L1_REQ) || (state_nx == L2_REQ);
            mem_req_addr  <= req_addr_nx;
            fill_we       <= fill_we_nx;
            fill_vpn      <= fill_vpn_nx;
            fill_ppn      <= fill_ppn_nx;
            fill_dirty    <= fill_dirty_nx;
            fault         <= fault_nx;
            fault_vpn     <= fault_vpn_nx;
            fault_cause   <= fault_cause_nx;
`ifdef PTW_TIMEOUT_EN
            wait_cnt      <= wait_cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_page_table_walker.sv
// tb_page_table_walker: directed and randomized walks against a behavioural page-table model.
// The timeout scenario runs only when PTW_TIMEOUT_EN is defined.
module tb_page_table_walker;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] ptbr;
    logic        miss_valid;
    logic [19:0] miss_vpn;
    logic        miss_ready;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        fill_we;
    logic [19:0] fill_vpn;
    logic [19:0] fill_ppn;
    logic        fill_dirty;
    logic        fault;
    logic [19:0] fault_vpn;
    logic [1:0]  fault_cause;
    logic        busy;

    int tests = 0;
    int fails = 0;

    page_table_walker #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .ptbr(ptbr),
        .miss_valid(miss_valid), .miss_vpn(miss_vpn), .miss_ready(miss_ready),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .fill_we(fill_we), .fill_vpn(fill_vpn), .fill_ppn(fill_ppn), .fill_dirty(fill_dirty),
        .fault(fault), .fault_vpn(fault_vpn), .fault_cause(fault_cause), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string where);
        check({where, "_miss_ready"},    miss_ready,    1);
        check({where, "_busy"},          busy,          0);
        check({where, "_mem_req_valid"}, mem_req_valid, 0);
        check({where, "_mem_req_addr"},  mem_req_addr,  0);
        check({where, "_fill_we"},       fill_we,       0);
        check({where, "_fill_vpn"},      fill_vpn,      0);
        check({where, "_fill_ppn"},      fill_ppn,      0);
        check({where, "_fill_dirty"},    fill_dirty,    0);
        check({where, "_fault"},         fault,         0);
        check({where, "_fault_vpn"},     fault_vpn,     0);
        check({where, "_fault_cause"},   fault_cause,   0);
    endtask

    // One walk against a two-entry memory. The expected outcome comes from the page-table rules
    // in plain arithmetic; the responder applies L1 stalls, random backpressure and response latency.
    task automatic walk(input logic [19:0] p, input logic [19:0] v,
                        input logic [31:0] pte1, input logic [31:0] pte2,
                        input int stall_l1, input int lat, input bit rand_bp,
                        input bit hold_miss, input bit drop_l2, input int exp_done);
        logic [31:0] exp_addr [2];
        int          exp_reqs;
        bit          exp_fault;
        logic [1:0]  exp_cause;
        int          nreq = 0;
        int          stalls = 0;
        int          countdown = 0;
        int          resp_idx = 0;
        bit          stalled = 0;
        bit          done = 0;

        exp_addr[0] = 32'(p) * 32'd4096 + 32'(v >> 10) * 32'd4;
        exp_addr[1] = 32'(pte1 >> 12) * 32'd4096 + 32'(v % 1024) * 32'd4;
        exp_cause   = 2'd0;
        if (pte1[0] == 1'b0) begin
            exp_reqs = 1; exp_fault = 1; exp_cause = 2'd1;
        end else if (drop_l2) begin
            exp_reqs = 2; exp_fault = 1; exp_cause = 2'd3;
        end else if (pte2[0] == 1'b0) begin
            exp_reqs = 2; exp_fault = 1; exp_cause = 2'd2;
        end else begin
            exp_reqs = 2; exp_fault = 0;
        end

        @(negedge clk);
        check("idle_ready", miss_ready, 1);
        ptbr = p; miss_vpn = v; miss_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge clk);
            miss_valid = hold_miss;
            miss_vpn   = ~v;
            ptbr       = 20'($urandom);

            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0 && !(resp_idx == 1 && drop_l2)) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = (resp_idx == 0) ? pte1 : pte2;
                end
            end

            if (fill_we || fault) begin
                if (exp_done >= 0) check("done_cycle", c, exp_done);
                check("outcome_fault", fault, exp_fault);
                check("outcome_fill", fill_we, !exp_fault);
                check("req_count", nreq, exp_reqs);
                if (exp_fault) begin
                    check("fault_cause", fault_cause, exp_cause);
                    check("fault_vpn", fault_vpn, v);
                end else begin
                    check("fill_vpn", fill_vpn, v);
                    check("fill_ppn", fill_ppn, pte2 >> 12);
                    check("fill_dirty", fill_dirty, pte2[1]);
                end
                miss_valid = 1'b0;
                done = 1;
            end else begin
                check("busy_during_walk", {busy, miss_ready}, 2'b10);
            end

            if (stalled) check("req_held", mem_req_valid, 1);
            stalled = 0;
            if (mem_req_valid) begin
                check("req_expected", nreq < exp_reqs, 1);
                if (nreq < exp_reqs) check("req_addr", mem_req_addr, exp_addr[nreq]);
                if (nreq == 0 && stalls < stall_l1) begin
                    mem_req_ready = 1'b0;
                    stalls++;
                end else if (rand_bp) begin
                    mem_req_ready = 1'($urandom_range(0, 1));
                end else begin
                    mem_req_ready = 1'b1;
                end
                if (mem_req_ready) begin
                    countdown = 1 + lat;
                    resp_idx  = nreq;
                    nreq++;
                end else begin
                    stalled = 1;
                end
            end else begin
                mem_req_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!done) check("walk_completed", done, 1);

        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        check("single_pulse", {fill_we, fault}, 2'b00);
        check("idle_after_walk", {miss_ready, busy}, 2'b10);
        if (!exp_fault) check("fill_ppn_held", fill_ppn, pte2 >> 12);
        else            check("fault_vpn_held", fault_vpn, v);
    endtask

    logic [31:0] r_pte1, r_pte2;

    initial begin
        reset = 1'b1;
        ptbr = '0; miss_valid = 1'b0; miss_vpn = '0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // Zero-wait success, L1 fault, L2 fault.
        walk(20'h00010, 20'h12345, 32'h00020001, 32'hABCDE003, 0, 0, 0, 0, 0, 5);
        walk(20'h00010, 20'h12345, 32'h00020000, 32'hABCDE003, 0, 0, 0, 0, 0, 3);
        walk(20'h00010, 20'h12345, 32'h00020001, 32'hABCDE002, 0, 0, 0, 0, 0, 5);
        // Three L1 stall cycles with a competing miss held high throughout.
        walk(20'h00010, 20'h12345, 32'h00020001, 32'hABCDE001, 3, 0, 0, 1, 0, 8);
        // Responses arriving late, on the last cycle before a timeout would fire.
        walk(20'hFFFFF, 20'hFFFFF, 32'hFFFFF001, 32'h12345001, 0, 3, 0, 0, 0, 11);
`ifdef PTW_TIMEOUT_EN
        walk(20'h00010, 20'h12345, 32'h00020001, 32'hABCDE003, 0, 0, 0, 0, 1, 8);
`endif

        for (int i = 0; i < 24; i++) begin
            r_pte1 = $urandom;
            r_pte1[0] = ($urandom_range(0, 7) != 0);
            r_pte2 = $urandom;
            r_pte2[0] = ($urandom_range(0, 7) != 0);
            walk(20'($urandom), 20'($urandom), r_pte1, r_pte2, $urandom_range(0, 2),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, -1);
        end

        // Reset in the middle of a walk, then stray responses that must be ignored.
        @(negedge clk);
        ptbr = 20'h00010; miss_vpn = 20'h0ABCD; miss_valid = 1'b1; mem_req_ready = 1'b1;
        @(negedge clk);
        miss_valid = 1'b0;
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_data = 32'h00020001;
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        check("pre_reset_busy", {busy, mem_req_valid}, 2'b11);
        #2 reset = 1'b1;
        #1 check_reset_values("mid_walk_reset");
        @(negedge clk);
        reset = 1'b0;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hABCDE003;
            @(negedge clk);
            check("stray_resp_quiet", {fill_we, fault, busy}, 3'b000);
        end
        mem_resp_valid = 1'b0;

        walk(20'h00010, 20'h12345, 32'h00020001, 32'hABCDE003, 0, 0, 0, 0, 0, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/page_table_walker.md
# page_table_walker

Hardware page-table walker that services TLB misses. On a miss it performs a two-level walk of the in-memory page table through a simple request/response memory port. It then drives the TLB fill port (write enable, VPN, PPN, dirty) with one single-cycle pulse, or raises a fault. It sits between the TLB miss output and the memory arbiter, and is the producer side of the TLB's write/fill interface.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles waited for a memory response. Only used when the timeout feature is compiled in. Range 1..255.

Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: reset, asynchronous, active-high.
- ptbr, in, 20: root page-table PPN; sampled at miss acceptance.
- miss_valid, in, 1: TLB miss request.
- miss_vpn, in, 20: missing virtual page number.
- miss_ready, out, 1: walker idle; a miss is accepted when miss_valid && miss_ready.
- mem_req_valid, out, 1: memory read request.
- mem_req_addr, out, 32: byte address of the PTE.
- mem_req_ready, in, 1: memory accepts the request.
- mem_resp_valid, in, 1: response data valid.
- mem_resp_data, in, 32: PTE; [31:12] PPN, [1] dirty, [0] valid.
- fill_we, out, 1: one-cycle TLB write pulse.
- fill_vpn, out, 20: VPN to write.
- fill_ppn, out, 20: PPN to write.
- fill_dirty, out, 1: dirty bit to write.
- fault, out, 1: one-cycle walk-failure pulse.
- fault_vpn, out, 20: VPN of the failed walk.
- fault_cause, out, 2: 01 = L1 PTE invalid, 10 = L2 PTE invalid, 11 = timeout.
- busy, out, 1: walk in progress (state not IDLE).

## Operation
- States:
  - IDLE → L1_REQ → L1_WAIT → L2_REQ → L2_WAIT → FILL → IDLE.
  - FAULT → IDLE.
- IDLE:
  - miss_ready=1.
  - On acceptance, latch miss_vpn and ptbr; go to L1_REQ.
- L1_REQ:
  - mem_req_valid=1, mem_req_addr = {ptbr, 12'b0} + {miss_vpn[19:10], 2'b00}.
  - Address and valid are held stable until mem_req_ready=1; then go to L1_WAIT.
- L1_WAIT:
  - On mem_resp_valid, if data[0]=0, go to FAULT with cause 01.
  - Otherwise latch data[31:12] as the L2 base; go to L2_REQ.
- L2_REQ:
  - mem_req_addr = {l2_base, 12'b0} + {miss_vpn[9:0], 2'b00}.
  - Same handshake as L1_REQ; then go to L2_WAIT.
- L2_WAIT:
  - On mem_resp_valid, if data[0]=0, go to FAULT with cause 10.
  - Otherwise latch the PPN and dirty bit; go to FILL.
- FILL:
  - fill_we=1 for exactly one cycle, with fill_vpn, fill_ppn, fill_dirty valid.
  - Then go to IDLE.
- FAULT:
  - fault=1 for exactly one cycle, with fault_vpn and fault_cause valid.
  - No fill_we. Then go to IDLE.
- Address arithmetic is 32-bit unsigned; it cannot overflow, because the offset is below 4 KiB and is added to a page-aligned base.
- mem_resp_valid outside the WAIT states is ignored.
- Only one walk is outstanding at a time. miss_valid while busy is not accepted.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE.
  - miss_ready=1; busy=0.
  - mem_req_valid=0; mem_req_addr=0.
  - fill_we=0; fill_vpn=0; fill_ppn=0; fill_dirty=0.
  - fault=0; fault_vpn=0; fault_cause=0.
- Zero-wait memory (ready high; response in the cycle after request acceptance):
  - Acceptance in cycle 0.
  - L1 request in cycle 1; L1 response in cycle 2.
  - L2 request in cycle 3; L2 response in cycle 4.
  - fill_we in cycle 5.
  - miss_ready returns high in cycle 6.
- Each cycle of mem_req_ready=0 or of a missing response adds one cycle.
- Fill and fault data outputs hold their last values after the pulse.
- Reset mid-walk:
  - Abandons the walk immediately; no fill or fault is produced.
  - A response arriving after reset is ignored.

## Configuration
- PTW_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to L1_WAIT or L2_WAIT.
  - It increments each cycle that mem_resp_valid=0.
  - When it reaches TIMEOUT_CYCLES, go to FAULT with cause 11.
  - A response arriving in the same cycle the limit is reached wins; the walk continues.
- PTW_TIMEOUT_EN undefined:
  - No counter; the WAIT states wait indefinitely.
  - Cause 11 is never produced.

## Test plan
- Reset: assert reset during a walk; all outputs take their reset values; a later mem_resp_valid=1 produces no fill_we or fault.
- Successful walk, zero-wait memory:
  - Stimulus: ptbr=0x00010, miss_vpn=0x12345.
  - Required: L1 address 0x00010120; L1 PTE 0x00020001 returned.
  - Required: L2 address 0x00020D14; L2 PTE 0xABCDE003 returned.
  - Required: fill_we pulse in cycle 5 with fill_vpn=0x12345, fill_ppn=0xABCDE, fill_dirty=1.
- L1 fault: L1 PTE 0x00020000 → fault pulse with cause 01 and fault_vpn=0x12345; no L2 request; no fill_we.
- L2 fault: L2 PTE 0xABCDE002 → fault pulse with cause 10; no fill_we.
- Backpressure: hold mem_req_ready=0 for 3 cycles in L1_REQ → mem_req_valid and mem_req_addr stable; walk completes 3 cycles later; a miss_valid asserted while busy is not accepted.
- Timeout (PTW_TIMEOUT_EN, TIMEOUT_CYCLES=4): no L2 response → fault pulse with cause 11, 4 cycles after entering L2_WAIT; then miss_ready=1.
